// File: rtl/farbborg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : farbborg_scanner
// Brief    : Framebuffer read engine. Fetches one 64-bit word per 8 LEDs,
//            converts channel brightness into PWM bits, shifts them into the
//            serial LED drivers, latches, and sequences row select / OE.
// Revision : 1.0 - initial release
// ============================================================================
module farbborg_scanner #(
  parameter int BLANK_CYCLES = 8,
  parameter int PWM_STEPS    = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic [6:0]  o_addrb,
  input  logic [63:0] i_dob,
  output logic        o_sdata,
  output logic        o_sclk,
  output logic        o_latch,
  output logic        o_oe_n,
  output logic [3:0]  o_row_sel,
  output logic        o_frame_start
);

  localparam logic [7:0] c_blank_last = 8'(BLANK_CYCLES - 1);
  localparam logic [7:0] c_pwm_last   = 8'(PWM_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_BLANK = 3'd4,
    S_LATCH = 3'd5
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_row,   w_row_nxt;
  logic [2:0] r_word,  w_word_nxt;
  logic [7:0] r_pwm,   w_pwm_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;     // shift phase (0..15) or blank count
  logic [6:0] r_bits,  w_bits_nxt;    // compare bits still waiting to shift
  logic [6:0] r_addrb, w_addrb_nxt;
  logic       r_sdata, w_sdata_nxt;
  logic       r_sclk,  w_sclk_nxt;
  logic       r_latch, w_latch_nxt;
  logic       r_oe_n,  w_oe_n_nxt;
  logic [3:0] r_row_sel, w_row_sel_nxt;
  logic       r_frame_start, w_frame_start_nxt;

  logic [7:0] w_cmp;
  logic       w_pwm_wrap;
  logic [7:0] w_pwm_inc;
  logic [3:0] w_row_inc;

  // One comparator per channel byte: LED is on while brightness exceeds pwm
  for (genvar k = 0; k < 8; k++) begin : g_cmp
    assign w_cmp[k] = (i_dob[8*k +: 8] > r_pwm);
  end

  // Position after the current PWM step completes
  assign w_pwm_wrap = (r_pwm == c_pwm_last);
  assign w_pwm_inc  = w_pwm_wrap ? 8'd0 : r_pwm + 8'd1;
  assign w_row_inc  = w_pwm_wrap ? r_row + 4'd1 : r_row;

  // Next-state and next-output decode; everything holds unless changed
  always_comb begin
    w_state_nxt       = r_state;
    w_row_nxt         = r_row;
    w_word_nxt        = r_word;
    w_pwm_nxt         = r_pwm;
    w_cnt_nxt         = r_cnt;
    w_bits_nxt        = r_bits;
    w_addrb_nxt       = r_addrb;
    w_sdata_nxt       = r_sdata;
    w_sclk_nxt        = r_sclk;
    w_latch_nxt       = 1'b0;
    w_oe_n_nxt        = r_oe_n;
    w_row_sel_nxt     = r_row_sel;
    w_frame_start_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_enable) begin
          w_state_nxt       = S_FETCH;
          w_row_nxt         = 4'd0;
          w_word_nxt        = 3'd0;
          w_pwm_nxt         = 8'd0;
          w_addrb_nxt       = 7'd0;
          w_frame_start_nxt = 1'b1;
        end
      end

      // RAM samples addrb at the end of this cycle
      S_FETCH: w_state_nxt = S_LOAD;

      // dob is valid now; present the first (byte 7) bit immediately
      S_LOAD: begin
        w_bits_nxt  = w_cmp[6:0];
        w_sdata_nxt = w_cmp[7];
        w_sclk_nxt  = 1'b0;
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_SHIFT;
      end

      S_SHIFT: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt[3:0] == 4'd15) begin
          w_sclk_nxt = 1'b0;
          w_cnt_nxt  = 8'd0;
          if (r_word != 3'd7) begin
            w_word_nxt  = r_word + 3'd1;
            w_addrb_nxt = {r_row, r_word + 3'd1};
            w_state_nxt = S_FETCH;
          end else if (r_pwm == 8'd0) begin
            // New row's first step: blank before switching row drivers
            w_oe_n_nxt    = 1'b1;
            w_row_sel_nxt = r_row;
            w_state_nxt   = S_BLANK;
          end else begin
            w_latch_nxt = 1'b1;
            w_state_nxt = S_LATCH;
          end
        end else if (r_cnt[0] == 1'b0) begin
          w_sclk_nxt = 1'b1;
        end else begin
          w_sclk_nxt  = 1'b0;
          w_sdata_nxt = r_bits[6];
          w_bits_nxt  = {r_bits[5:0], 1'b0};
        end
      end

      S_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_cnt_nxt   = 8'd0;
          w_latch_nxt = 1'b1;
          w_state_nxt = S_LATCH;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      S_LATCH: begin
        w_word_nxt = 3'd0;
        if (i_enable) begin
          w_pwm_nxt         = w_pwm_inc;
          w_row_nxt         = w_row_inc;
          w_addrb_nxt       = {w_row_inc, 3'd0};
          w_oe_n_nxt        = 1'b0;
          w_frame_start_nxt = (w_pwm_inc == 8'd0) && (w_row_inc == 4'd0);
          w_state_nxt       = S_FETCH;
        end else begin
          // Stop cleanly; a later enable restarts from the frame origin
          w_pwm_nxt   = 8'd0;
          w_row_nxt   = 4'd0;
          w_oe_n_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_row         <= 4'd0;
      r_word        <= 3'd0;
      r_pwm         <= 8'd0;
      r_cnt         <= 8'd0;
      r_bits        <= 7'd0;
      r_addrb       <= 7'd0;
      r_sdata       <= 1'b0;
      r_sclk        <= 1'b0;
      r_latch       <= 1'b0;
      r_oe_n        <= 1'b1;
      r_row_sel     <= 4'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row         <= w_row_nxt;
      r_word        <= w_word_nxt;
      r_pwm         <= w_pwm_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bits        <= w_bits_nxt;
      r_addrb       <= w_addrb_nxt;
      r_sdata       <= w_sdata_nxt;
      r_sclk        <= w_sclk_nxt;
      r_latch       <= w_latch_nxt;
      r_oe_n        <= w_oe_n_nxt;
      r_row_sel     <= w_row_sel_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign o_addrb       = r_addrb;
  assign o_sdata       = r_sdata;
  assign o_sclk        = r_sclk;
  assign o_latch       = r_latch;
  assign o_oe_n        = r_oe_n;
  assign o_row_sel     = r_row_sel;
  assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_farbborg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_farbborg_scanner
// Brief    : Self-checking bench for farbborg_scanner (default instance plus a
//            short-frame instance for row wrap / frame period).
// Revision : 1.0 - initial release
// ============================================================================
module tb_farbborg_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        enable_s = 1'b0;
  logic [6:0]  addrb, addrb_s;
  logic [63:0] dob = '0, dob_s = '0;
  logic        sdata, sclk, latch, oe_n, frame_start;
  logic        sdata_s, sclk_s, latch_s, oe_n_s, frame_start_s;
  logic [3:0]  row_sel, row_sel_s;

  logic [63:0] mem [0:127];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  farbborg_scanner #(.BLANK_CYCLES(8), .PWM_STEPS(255)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .o_addrb(addrb),
    .i_dob(dob), .o_sdata(sdata), .o_sclk(sclk), .o_latch(latch),
    .o_oe_n(oe_n), .o_row_sel(row_sel), .o_frame_start(frame_start)
  );

  farbborg_scanner #(.BLANK_CYCLES(3), .PWM_STEPS(2)) u_small (
    .i_clk(clk), .i_reset(reset), .i_enable(enable_s), .o_addrb(addrb_s),
    .i_dob(dob_s), .o_sdata(sdata_s), .o_sclk(sclk_s), .o_latch(latch_s),
    .o_oe_n(oe_n_s), .o_row_sel(row_sel_s), .o_frame_start(frame_start_s)
  );

  // Framebuffer RAM read ports, one registered cycle of latency
  always @(posedge clk) begin
    dob   <= mem[addrb];
    dob_s <= mem[addrb_s];
  end

  // Monitor for the default instance: collects shifted bits per PWM step
  logic        mon_clr = 1'b0;
  int          cyc = 0;
  logic [63:0] vcur = '0;
  logic [63:0] steps [0:299];
  int          latch_t [0:299];
  int          oe_run_at [0:299];
  int          nbits_at [0:299];
  logic [3:0]  rowsel_at [0:299];
  int          nlatch = 0, nbits_cur = 0, oe_run = 0, fs_count = 0, sclk_rises = 0;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_sclk <= sclk;
    if (mon_clr) begin
      nlatch <= 0; nbits_cur <= 0; oe_run <= 0; fs_count <= 0; sclk_rises <= 0;
    end else begin
      if (sclk && !prev_sclk) begin
        vcur       <= {vcur[62:0], sdata};
        sclk_rises <= sclk_rises + 1;
      end
      if (frame_start) fs_count <= fs_count + 1;
      if (latch) begin
        if (nlatch < 300) begin
          steps[nlatch]     <= vcur;
          latch_t[nlatch]   <= cyc;
          oe_run_at[nlatch] <= oe_run;
          nbits_at[nlatch]  <= nbits_cur;
          rowsel_at[nlatch] <= row_sel;
        end
        nlatch    <= nlatch + 1;
        nbits_cur <= 0;
        oe_run    <= 0;
      end else begin
        if (sclk && !prev_sclk) nbits_cur <= nbits_cur + 1;
        oe_run <= oe_n ? oe_run + 1 : 0;
      end
    end
  end

  // Monitor for the short-frame instance
  int         nlatch_s = 0, fs_count_s = 0;
  int         latch_t_s [0:63];
  logic [3:0] rowsel_s_at [0:63];
  int         fs_t_s [0:3];

  always @(negedge clk) begin
    if (latch_s) begin
      if (nlatch_s < 64) begin
        latch_t_s[nlatch_s]   <= cyc;
        rowsel_s_at[nlatch_s] <= row_sel_s;
      end
      nlatch_s <= nlatch_s + 1;
    end
    if (frame_start_s) begin
      if (fs_count_s < 4) fs_t_s[fs_count_s] <= cyc;
      fs_count_s <= fs_count_s + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         idx;   // latch index (row*255 + pwm in the main run)
    int         word;
    logic [7:0] exp;   // bits in shift order, byte 7 in the MSB
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [63:0] v;
    logic        bad;
    int          nbad, lmark, srmark;

    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[0]  = 64'h01FF_0000_0000_0080;   // row 0 word 0
    mem[7]  = 64'hFF00_FF00_0201_0080;   // row 0 word 7
    mem[8]  = 64'h8000_0000_0000_0000;   // row 1 word 0
    mem[15] = 64'h0000_0000_0000_00FF;   // row 1 word 7

    vecs[0]  = '{0,   0, 8'b1100_0001};
    vecs[1]  = '{1,   0, 8'b0100_0001};
    vecs[2]  = '{128, 0, 8'b0100_0000};
    vecs[3]  = '{254, 0, 8'b0100_0000};
    vecs[4]  = '{0,   7, 8'b1010_1101};
    vecs[5]  = '{1,   7, 8'b1010_1001};
    vecs[6]  = '{2,   7, 8'b1010_0001};
    vecs[7]  = '{128, 7, 8'b1010_0000};
    vecs[8]  = '{2,   3, 8'b0000_0000};
    vecs[9]  = '{255, 0, 8'b1000_0000};
    vecs[10] = '{255, 7, 8'b0000_0001};

    // ---- reset held, then 100 idle cycles with enable low ----
    repeat (3) tick();
    check("rst_oe_n", oe_n, 1);
    reset = 1'b0;
    mon_clr = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (addrb !== 0 || sdata !== 0 || sclk !== 0 || latch !== 0 ||
          oe_n !== 1 || row_sel !== 0 || frame_start !== 0) bad = 1'b1;
    end
    check("idle_outputs_stable", bad, 0);
    mon_clr = 1'b0;

    // ---- start: frame_start, addrb=0, first sclk rise 3 cycles later ----
    enable = 1'b1;
    tick();
    check("start_frame_start", frame_start, 1);
    check("start_addrb", addrb, 0);
    check("start_sclk_c1", sclk, 0);
    tick();
    check("start_fs_pulse_len", frame_start, 0);
    check("start_sclk_c2", sclk, 0);
    tick();
    check("start_sclk_c3", sclk, 0);
    check("first_sdata", sdata, 1);
    tick();
    check("first_sclk_rise", sclk, 1);

    // ---- run through row 0 and the first step of row 1 ----
    for (int i = 0; i < 40000 && nlatch < 256; i++) tick();
    check("row0_run_done", (nlatch >= 256), 1);

    for (int i = 0; i < 11; i++) begin
      v = steps[vecs[i].idx];
      check($sformatf("bits_idx%0d_w%0d", vecs[i].idx, vecs[i].word),
            v[63 - 8*vecs[i].word -: 8], vecs[i].exp);
    end

    nbad = 0;
    for (int n = 1; n < 255; n++)
      if (latch_t[n] - latch_t[n-1] != 145) nbad++;
    check("latch_spacing_bad", nbad, 0);
    check("row_switch_spacing", latch_t[255] - latch_t[254], 153);
    check("row_switch_oe_high", oe_run_at[255], 8);
    check("steady_oe_high", oe_run_at[100], 0);
    check("steady_nbits", nbits_at[100], 64);
    check("rowsel_before", rowsel_at[254], 0);
    check("rowsel_after", rowsel_at[255], 1);
    check("frame_start_once", fs_count, 1);

    // ---- drop enable mid-SHIFT of word 3 ----
    for (int i = 0; i < 300 && addrb[2:0] != 3'd3; i++) tick();
    check("found_word3", addrb[2:0], 3);
    repeat (6) tick();
    lmark = nlatch;
    enable = 1'b0;
    repeat (200) tick();
    srmark = sclk_rises;
    repeat (200) tick();
    check("drop_one_latch", nlatch, lmark + 1);
    check("drop_step_complete", nbits_at[lmark], 64);
    check("drop_oe_n", oe_n, 1);
    check("drop_no_sclk", sclk_rises, srmark);

    // ---- re-enable restarts at the frame origin ----
    enable = 1'b1;
    tick();
    check("reen_frame_start", frame_start, 1);
    check("reen_addrb", addrb, 0);

    // ---- reset during BLANK ----
    for (int i = 0; i < 300 && nbits_cur < 64; i++) tick();
    check("reached_blank", nbits_cur, 64);
    repeat (2) tick();
    lmark = nlatch;
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    check("rstblank_oe_n", oe_n, 1);
    check("rstblank_latch", latch, 0);
    check("rstblank_row_sel", row_sel, 0);
    check("rstblank_sclk", sclk, 0);
    check("rstblank_addrb", addrb, 0);
    reset = 1'b0;
    srmark = sclk_rises;
    repeat (50) tick();
    check("rstblank_no_sclk", sclk_rises, srmark);
    check("rstblank_no_latch", nlatch, lmark);

    // ---- short frame instance: row wrap and frame period ----
    enable_s = 1'b1;
    for (int i = 0; i < 6000 && nlatch_s < 33; i++) tick();
    check("small_run_done", (nlatch_s >= 33), 1);
    check("small_fs_count", fs_count_s, 2);
    check("small_frame_period", fs_t_s[1] - fs_t_s[0], 4688);
    check("small_step_spacing", latch_t_s[1] - latch_t_s[0], 145);
    check("small_row_spacing", latch_t_s[2] - latch_t_s[1], 148);
    check("small_rowsel_15", rowsel_s_at[30], 15);
    check("small_rowsel_wrap", rowsel_s_at[32], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
